if_id_hazard_reg: RTL and testbench
===================================

Name: if_id_hazard_reg

Overview:
Parametrised IF/ID pipeline register for the pipelined MIPS core, between instruction fetch and decode.
- Captures PC+4 and instruction each cycle.
- Inserts a configurable number of NOP bubbles after branch (beq/bne), jump (j) and multiply (R-type funct 25).
- Supports downstream stall and control-hazard flush.
- Drives a fetch-hold signal so the instruction following a hazard is held at the fetch stage, not lost.

Parameters:
- PC_W, 32, width of PC+4 path
- INST_W, 32, instruction width (must be ≥32; opcode at [31:26], funct at [5:0])
- BR_BUBBLES, 2, NOPs inserted after opcode 4 or 5
- JMP_BUBBLES, 1, NOPs inserted after opcode 2
- MUL_BUBBLES, 34, NOPs inserted after opcode 0 with funct 25
- CNT_W, 6, bubble counter width; must hold the largest *_BUBBLES value

Ports:
- clk, input, 1, rising-edge clock
- rst, input, 1, asynchronous active-low reset
- stall_i, input, 1, downstream stall: hold all registers
- flush_i, input, 1, discard the current capture or bubble sequence; output NOP
- pc_incr_i, input, PC_W, PC+4 from fetch
- inst_i, input, INST_W, instruction from instruction memory
- pc_incr_o, output, PC_W, registered PC+4 to decode
- inst_o, output, INST_W, registered instruction to decode; 0 = NOP
- valid_o, output, 1, inst_o is a real instruction, not a bubble
- fetch_hold_o, output, 1, combinational; PC and fetch must hold while 1
- bubble_cnt_o, output, CNT_W, remaining bubbles (debug/verification)

Behaviour:
- Reset (rst=0, asynchronous, any time):
  - pc_incr_o=0, inst_o=0, valid_o=0, bubble_cnt_o=0, state=PASS, fetch_hold_o=0.
  - Reset mid-bubble aborts the sequence.
- State machine: PASS, BUBBLE. fetch_hold_o = (state==BUBBLE).
- Per rising edge, priority order: flush > stall > state action.
- flush_i=1:
  - inst_o<=0, valid_o<=0, pc_incr_o<=pc_incr_i, count<=0, state<=PASS.
  - Flush overrides stall when both are asserted.
- stall_i=1 (no flush): all registers, state and count hold; fetch_hold_o unchanged.
- PASS:
  - Always: pc_incr_o<=pc_incr_i, inst_o<=inst_i, valid_o<=1.
  - Decode inst_i to get N:
    - opcode 4/5 → N=BR_BUBBLES
    - opcode 2 → N=JMP_BUBBLES
    - opcode 0 with funct 25 → N=MUL_BUBBLES
    - anything else → N=0
  - If N>0: count<=N, state<=BUBBLE. If N=0: stay in PASS.
- BUBBLE:
  - inst_o<=0, valid_o<=0, pc_incr_o<=pc_incr_i, count<=count-1.
  - If count==1: state<=PASS.
  - inst_i is ignored; fetch holds it stable.
- Latency and counting:
  - One cycle input to output.
  - A hazard instruction is followed by exactly N NOP cycles (stall cycles excluded).
  - The next instruction appears on the (N+1)th active edge after the hazard.
- Back-to-back hazards: the held instruction is itself decoded on exit from BUBBLE. Each hazard starts its own sequence; no overlap or merge.
- Parameter set to 0: that class passes with no bubbles and fetch_hold_o never asserts for it.
- Counter never wraps: decrement only in BUBBLE, where count≥1.
- inst_i = 0 (NOP) in PASS is captured with valid_o=1.

Test Plan:
1. Reset: rst=0 mid-operation with count=5 → all outputs 0 immediately, no clk edge needed; after rst=1, the first edge captures inst_i with valid_o=1.
2. beq 0x10220003 at PC+4=0x8 → inst_o=0x10220003 for 1 cycle, then 2 cycles inst_o=0/valid_o=0 with fetch_hold_o=1; the held add 0x00221820 appears on the 3rd edge after beq.
3. mul 0x00430019 → 1 cycle mul, then 34 NOP cycles with bubble_cnt_o counting 34→1, then the next instruction; repeat with MUL_BUBBLES=4 → 4 NOPs.
4. j 0x08000004 followed by bne 0x14220002 held → 1 NOP, bne, 2 NOPs, next instruction (back-to-back hazards).
5. stall_i=1 for 3 cycles during a beq bubble at count=1 → outputs and count frozen; 1 NOP after release, then the held instruction; total NOPs still 2.
6. flush_i=1 together with stall_i=1 during a mul bubble at count=20 → next edge inst_o=0, valid_o=0, count=0, state=PASS, fetch_hold_o=0; the following edge captures the new inst_i.

Source files
------------

// File: rtl/if_id_hazard_if.sv
// if_id_hazard_if: fetch-to-decode bus carried through the IF/ID hazard register.
interface if_id_hazard_if #(
    parameter int PC_W   = 32,
    parameter int INST_W = 32,
    parameter int CNT_W  = 6
);
    logic              stall_i;
    logic              flush_i;
    logic [PC_W-1:0]   pc_incr_i;
    logic [INST_W-1:0] inst_i;
    logic [PC_W-1:0]   pc_incr_o;
    logic [INST_W-1:0] inst_o;
    logic              valid_o;
    logic              fetch_hold_o;
    logic [CNT_W-1:0]  bubble_cnt_o;

    modport master (
        output stall_i, flush_i, pc_incr_i, inst_i,
        input  pc_incr_o, inst_o, valid_o, fetch_hold_o, bubble_cnt_o
    );
    modport slave (
        input  stall_i, flush_i, pc_incr_i, inst_i,
        output pc_incr_o, inst_o, valid_o, fetch_hold_o, bubble_cnt_o
    );
endinterface

// File: rtl/if_id_hazard_reg.sv
// if_id_hazard_reg: IF/ID pipeline register that inserts NOP bubbles after
// branch, jump and multiply, holding fetch while the bubbles drain.
module if_id_hazard_reg #(
    parameter int PC_W        = 32,
    parameter int INST_W      = 32,
    parameter int BR_BUBBLES  = 2,
    parameter int JMP_BUBBLES = 1,
    parameter int MUL_BUBBLES = 34,
    parameter int CNT_W       = 6
) (
    input logic clk,
    input logic rst,
    if_id_hazard_if.slave bus
);
    typedef enum logic {PASS, BUBBLE} state_t;
    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  n;
    logic [5:0]        op;
    logic [5:0]        fn;
    logic [PC_W-1:0]   pc_q;
    logic [INST_W-1:0] inst_q;
    logic              valid_q;

    assign op = bus.inst_i[31:26];
    assign fn = bus.inst_i[5:0];

    // bubble count owed by the instruction currently offered by fetch
    always_comb n = (op == 6'd4 || op == 6'd5) ? CNT_W'(BR_BUBBLES) :
                    (op == 6'd2)               ? CNT_W'(JMP_BUBBLES) :
                    (op == 6'd0 && fn == 6'd25) ? CNT_W'(MUL_BUBBLES) : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= PASS;
            cnt     <= '0;
            pc_q    <= '0;
            inst_q  <= '0;
            valid_q <= 1'b0;
        end else if (bus.flush_i) begin
            state   <= PASS;
            cnt     <= '0;
            pc_q    <= bus.pc_incr_i;
            inst_q  <= '0;
            valid_q <= 1'b0;
        end else if (!bus.stall_i) begin
            pc_q    <= bus.pc_incr_i;
            inst_q  <= state == PASS ? bus.inst_i : '0;
            valid_q <= state == PASS;
            if (state == PASS) begin
                cnt   <= n;
                state <= n != '0 ? BUBBLE : PASS;
            end else begin
                cnt   <= cnt - 1'b1;
                state <= cnt == CNT_W'(1) ? PASS : BUBBLE;
            end
        end
    end

    assign bus.pc_incr_o    = pc_q;
    assign bus.inst_o       = inst_q;
    assign bus.valid_o      = valid_q;
    assign bus.fetch_hold_o = state == BUBBLE;
    assign bus.bubble_cnt_o = cnt;
endmodule

// File: tb/tb_if_id_hazard_reg.sv
// tb_if_id_hazard_reg: scoreboard bench for two differently parameterised
// IF/ID hazard registers driven by a common fetch stream.
module tb_if_id_hazard_reg;
    localparam int BR0 = 2, J0 = 1, M0 = 34;
    localparam int BR1 = 0, J1 = 3, M1 = 4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        v;
        logic        h;
        logic [5:0]  cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    if_id_hazard_if b0 ();
    if_id_hazard_if #(.CNT_W(3)) b1 ();

    if_id_hazard_reg dut0 (.clk(clk), .rst(rst), .bus(b0));
    if_id_hazard_reg #(
        .BR_BUBBLES(BR1), .JMP_BUBBLES(J1), .MUL_BUBBLES(M1), .CNT_W(3)
    ) dut1 (.clk(clk), .rst(rst), .bus(b1));

    exp_t        q0[$];
    exp_t        q1[$];
    exp_t        cur[2];
    int          owed[2];
    int          checks = 0;
    int          errors = 0;
    bit          adv = 1'b1;
    logic [31:0] pc = '0;
    logic [31:0] inst = '0;

    // bubbles a given instruction owes on DUT k
    function automatic int nb(int k, logic [31:0] x);
        logic [5:0] op;
        op = x[31:26];
        if (op == 6'd4 || op == 6'd5) return k != 0 ? BR1 : BR0;
        if (op == 6'd2) return k != 0 ? J1 : J0;
        if (op == 6'd0 && x[5:0] == 6'd25) return k != 0 ? M1 : M0;
        return 0;
    endfunction

    function automatic logic [31:0] rnd_inst();
        logic [31:0] r;
        int          c;
        r = $urandom;
        c = $urandom_range(0, 9);
        if (c == 0) r[31:26] = 6'd4;
        else if (c == 1) r[31:26] = 6'd5;
        else if (c == 2) r[31:26] = 6'd2;
        else if (c == 3) begin r[31:26] = 6'd0; r[5:0] = 6'd25; end
        else if (c == 4) r = '0;
        else if (c == 5) begin r[31:26] = 6'd0; r[5:0] = 6'd32; end
        else if (c == 6) r[31:26] = 6'd3;
        else if (c == 7) r[31:26] = 6'd35;
        else r[31:26] = 6'd8;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
        end
    endtask

    task automatic step(input int k, input bit st, input bit fl);
        if (fl) begin
            owed[k] = 0;
            cur[k] = '0;
            cur[k].pc = pc;
        end else if (!st) begin
            if (owed[k] == 0) begin
                cur[k].inst = inst;
                cur[k].v = 1'b1;
                owed[k] = nb(k, inst);
            end else begin
                cur[k].inst = '0;
                cur[k].v = 1'b0;
                owed[k]--;
            end
            cur[k].pc = pc;
            cur[k].h = owed[k] != 0;
            cur[k].cnt = 6'(owed[k]);
        end
    endtask

    // one fetch cycle: present inputs, advance the reference model, queue expectations
    task automatic cyc(input bit r, input bit st, input bit fl, input logic [31:0] cand);
        bit cap;
        @(posedge clk);
        #2;
        if (adv) begin
            inst = cand;
            pc += 32'd4;
        end
        rst = r;
        b0.stall_i = st;  b1.stall_i = st;
        b0.flush_i = fl;  b1.flush_i = fl;
        b0.pc_incr_i = pc; b1.pc_incr_i = pc;
        b0.inst_i = inst; b1.inst_i = inst;
        if (!r) begin
            owed = '{0, 0};
            cur[0] = '0;
            cur[1] = '0;
            adv = 1'b1;
            #1;
            chk("rst_pc", b0.pc_incr_o, 0);
            chk("rst_inst", b0.inst_o, 0);
            chk("rst_valid", b0.valid_o, 0);
            chk("rst_hold", b0.fetch_hold_o, 0);
            chk("rst_cnt", b0.bubble_cnt_o, 0);
            chk("rst_cnt1", b1.bubble_cnt_o, 0);
        end else begin
            cap = !fl && !st && owed[0] == 0 && owed[1] == 0;
            step(0, st, fl);
            step(1, st, fl);
            adv = fl || cap;
        end
        q0.push_back(cur[0]);
        q1.push_back(cur[1]);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q0.size() != 0) begin
                e = q0.pop_front();
                chk("d0_pc", b0.pc_incr_o, e.pc);
                chk("d0_inst", b0.inst_o, e.inst);
                chk("d0_valid", b0.valid_o, e.v);
                chk("d0_hold", b0.fetch_hold_o, e.h);
                chk("d0_cnt", b0.bubble_cnt_o, e.cnt);
            end
            if (q1.size() != 0) begin
                e = q1.pop_front();
                chk("d1_pc", b1.pc_incr_o, e.pc);
                chk("d1_inst", b1.inst_o, e.inst);
                chk("d1_valid", b1.valid_o, e.v);
                chk("d1_hold", b1.fetch_hold_o, e.h);
                chk("d1_cnt", b1.bubble_cnt_o, e.cnt);
            end
        end
    end

    initial begin
        int r;
        owed = '{0, 0};
        cur[0] = '0;
        cur[1] = '0;
        b0.stall_i = 1'b0; b1.stall_i = 1'b0;
        b0.flush_i = 1'b0; b1.flush_i = 1'b0;
        b0.pc_incr_i = '0; b1.pc_incr_i = '0;
        b0.inst_i = '0;    b1.inst_i = '0;
        cyc(0, 0, 0, 32'h00221820);
        cyc(1, 0, 0, 32'h10220003);
        cyc(1, 0, 0, 32'h00221820);
        repeat (3) cyc(1, 0, 0, 32'h00832020);
        cyc(1, 0, 0, 32'h00430019);
        repeat (37) cyc(1, 0, 0, 32'h00221820);
        cyc(1, 0, 0, 32'h08000004);
        cyc(1, 0, 0, 32'h14220002);
        repeat (6) cyc(1, 0, 0, 32'h00221820);
        cyc(1, 0, 0, 32'h10220003);
        cyc(1, 0, 0, 32'h00832020);
        repeat (3) cyc(1, 1, 0, 32'h00832020);
        repeat (3) cyc(1, 0, 0, 32'h00221820);
        cyc(1, 0, 0, 32'h00430019);
        repeat (14) cyc(1, 0, 0, 32'h00221820);
        cyc(1, 1, 1, 32'h8c410004);
        repeat (3) cyc(1, 0, 0, 32'h8c410004);
        cyc(1, 0, 0, 32'h00430019);
        repeat (29) cyc(1, 0, 0, 32'h00221820);
        cyc(0, 0, 0, 32'h00221820);
        repeat (3) cyc(1, 0, 0, 32'h00832020);
        repeat (400) begin
            r = $urandom_range(0, 99);
            cyc(1, r >= 2 && r < 14, r < 4, rnd_inst());
        end
        repeat (3) cyc(1, 0, 0, 32'h0);
        @(posedge clk);
        #5;
        chk("drain", 64'(q0.size() + q1.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
